// File: rtl/axis_maxpool_out_serializer_pkg.sv
// Shared constants, sizing helpers and FSM encoding for the maxpool output serializer.
// The default configuration is 8-bit words, 2 groups of 4 units, KH_MAX=3 and 8 words out.
package axis_maxpool_out_serializer_pkg;

   localparam int DEF_WORD_WIDTH = 8;
   localparam int DEF_GROUPS     = 2;
   localparam int DEF_UNITS      = 4;
   localparam int DEF_KH_MAX     = 3;
   localparam int DEF_OUT_WORDS  = 8;

   function automatic int calc_units_edges(input int units, input int kh_max);
      return units + 2 * (kh_max / 2);
   endfunction

   // A single chunk still needs a 1-bit pointer.
   function automatic int calc_ptr_w(input int n_chunks);
      return (n_chunks > 1) ? $clog2(n_chunks) : 1;
   endfunction

   localparam int UNITS_EDGES = calc_units_edges(DEF_UNITS, DEF_KH_MAX);
   localparam int N_IN        = 2 * DEF_GROUPS * UNITS_EDGES;
   localparam int N_CHUNKS    = N_IN / DEF_OUT_WORDS;
   localparam int PTR_W       = calc_ptr_w(N_CHUNKS);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

endpackage

// File: rtl/axis_maxpool_out_serializer_seek.sv
// Finds the lowest non-empty chunk overall and the lowest non-empty chunk above cur.
// When the mask is all zero, first returns 0 and has_next stays low.
module axis_maxpool_out_serializer_seek
   import axis_maxpool_out_serializer_pkg::*;
#(
   parameter int N_CH  = N_CHUNKS,
   parameter int PTR_B = PTR_W
) (
   input  logic [N_CH-1:0]  mask,
   input  logic [PTR_B-1:0] cur,
   output logic [PTR_B-1:0] first,
   output logic [PTR_B-1:0] next,
   output logic             has_next
);

   // Walking downward leaves the lowest qualifying index in each result.
   always_comb begin
      first    = '0;
      next     = '0;
      has_next = 1'b0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (mask[k]) begin
            first = PTR_B'(k);
            if (k > int'(cur)) begin
               next     = PTR_B'(k);
               has_next = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/axis_maxpool_out_serializer.sv
// Serializes one wide edge-padded maxpool beat into OUT_WORDS-word beats, skipping
// chunks with no kept words and preserving the packet tlast.
//
//   state | meaning
//   IDLE  | buffer empty, s_axis_tready high, waiting for a wide beat
//   EMIT  | presenting chunk[ptr] of the buffered beat on m_axis
module axis_maxpool_out_serializer
   import axis_maxpool_out_serializer_pkg::*;
#(
   parameter int  WORD_WIDTH = DEF_WORD_WIDTH,
   parameter int  GROUPS     = DEF_GROUPS,
   parameter int  UNITS      = DEF_UNITS,
   parameter int  KH_MAX     = DEF_KH_MAX,
   parameter int  OUT_WORDS  = DEF_OUT_WORDS,
   localparam int U_EDGES    = calc_units_edges(UNITS, KH_MAX),
   localparam int IN_WORDS   = 2 * GROUPS * U_EDGES,
   localparam int CHUNKS     = IN_WORDS / OUT_WORDS,
   localparam int PTR_BITS   = calc_ptr_w(CHUNKS),
   localparam int IN_BITS    = IN_WORDS * WORD_WIDTH,
   localparam int OUT_BITS   = OUT_WORDS * WORD_WIDTH
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic [IN_BITS-1:0]   s_axis_tdata,
   input  logic [IN_WORDS-1:0]  s_axis_tkeep,
   input  logic                 s_axis_tlast,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic [OUT_BITS-1:0]  m_axis_tdata,
   output logic [OUT_WORDS-1:0] m_axis_tkeep,
   output logic                 m_axis_tlast
);

   state_t               state, state_nxt;
   logic [PTR_BITS-1:0]  ptr, ptr_nxt;
   logic                 m_valid_q;
   logic [IN_BITS-1:0]   buf_data;
   logic [IN_WORDS-1:0]  buf_keep;
   logic                 buf_last;
   logic [CHUNKS-1:0]    buf_mask;

   logic [CHUNKS-1:0]    in_mask;
   logic                 in_empty;
   logic [PTR_BITS-1:0]  in_first;
   logic [PTR_BITS-1:0]  in_next_unused;
   logic                 in_has_next_unused;
   logic [PTR_BITS-1:0]  buf_first_unused;
   logic [PTR_BITS-1:0]  buf_next;
   logic                 buf_has_next;

   logic                 s_ready;
   logic                 accept;
   logic                 load;

   logic [OUT_BITS-1:0]  chunk_data [CHUNKS];
   logic [OUT_WORDS-1:0] chunk_keep [CHUNKS];

   always_comb begin
      in_mask = '0;
      for (int k = 0; k < CHUNKS; k++) begin
         in_mask[k] = |s_axis_tkeep[k*OUT_WORDS +: OUT_WORDS];
      end
   end

   assign in_empty = ~|in_mask;

   axis_maxpool_out_serializer_seek #(
      .N_CH  (CHUNKS),
      .PTR_B (PTR_BITS)
   ) u_seek_in (
      .mask     (in_mask),
      .cur      ('0),
      .first    (in_first),
      .next     (in_next_unused),
      .has_next (in_has_next_unused)
   );

   axis_maxpool_out_serializer_seek #(
      .N_CH  (CHUNKS),
      .PTR_B (PTR_BITS)
   ) u_seek_buf (
      .mask     (buf_mask),
      .cur      (ptr),
      .first    (buf_first_unused),
      .next     (buf_next),
      .has_next (buf_has_next)
   );

   // The final chunk can hand over to a new wide beat in the same cycle, so
   // s_axis_tready looks through to m_axis_tready combinationally.
   always_comb begin
      s_ready   = 1'b0;
      state_nxt = state;
      ptr_nxt   = ptr;
      if (!areset) begin
         s_ready = (state == IDLE) || (m_axis_tready && !buf_has_next);
      end
      accept = s_axis_tvalid && s_ready;
      // An empty beat without tlast carries nothing worth emitting.
      load   = accept && !(in_empty && !s_axis_tlast);
      case (state)
         IDLE: begin
            if (load) state_nxt = EMIT;
         end
         EMIT: begin
            if (m_axis_tready) begin
               if (buf_has_next) ptr_nxt = buf_next;
               else if (!load)   state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (load) ptr_nxt = in_empty ? '0 : in_first;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state     <= IDLE;
         ptr       <= '0;
         m_valid_q <= 1'b0;
         buf_data  <= '0;
         buf_keep  <= '0;
         buf_last  <= 1'b0;
         buf_mask  <= '0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         m_valid_q <= (state_nxt == EMIT);
         if (load) begin
            buf_data <= s_axis_tdata;
            buf_keep <= in_empty ? '0 : s_axis_tkeep;
            buf_last <= s_axis_tlast;
            buf_mask <= in_mask;
         end
      end
   end

   genvar c;
   for (c = 0; c < CHUNKS; c++) begin : g_chunk
      assign chunk_data[c] = buf_data[c*OUT_BITS +: OUT_BITS];
      assign chunk_keep[c] = buf_keep[c*OUT_WORDS +: OUT_WORDS];
   end

   assign s_axis_tready = s_ready;
   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tdata  = chunk_data[ptr];
   assign m_axis_tkeep  = chunk_keep[ptr];
   // With an all-zero mask has_next is low, so the lone keep-0 beat carries tlast.
   assign m_axis_tlast  = m_valid_q && buf_last && !buf_has_next;

endmodule
